// File: rtl/mult_booth.sv
// Multicycle 32x32 radix-2 Booth multiplier, 33 RUN cycles per product, hi/lo outputs.
// Optional MULTU support through the MULT_UNSIGNED_EN macro (adds i_unsigned_op).
module mult_booth (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
`ifdef MULT_UNSIGNED_EN
   input  logic        i_unsigned_op,
`endif
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo
);

   // state  | meaning
   // S_IDLE | waiting for i_start; hi/lo hold last result
   // S_RUN  | Booth step + arithmetic shift each edge, 33 edges
   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t      r_state;
   logic [32:0] r_m;
   logic [32:0] r_a;
   logic [32:0] r_q;
   logic        r_q1;
   logic [5:0]  r_cnt;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_sign_ext;
   logic [32:0] w_m_ext;
   logic [32:0] w_q_ext;
   logic [32:0] w_a_sum;
   logic [32:0] w_a_shift;
   logic [32:0] w_q_shift;
   logic [63:0] w_product;

`ifdef MULT_UNSIGNED_EN
   assign w_sign_ext = ~i_unsigned_op;
`else
   assign w_sign_ext = 1'b1;
`endif

   assign w_m_ext = {w_sign_ext & i_a[31], i_a};
   assign w_q_ext = {w_sign_ext & i_b[31], i_b};

   always_comb begin
      w_a_sum = r_a;
      case ({r_q[0], r_q1})
         2'b01:   w_a_sum = r_a + r_m;
         2'b10:   w_a_sum = r_a - r_m;
         default: w_a_sum = r_a;
      endcase
   end

   // {A,Q,q_1} >>> 1 with A[32] replicated; product is the low 64 bits of {A,Q}
   assign w_a_shift = {w_a_sum[32], w_a_sum[32:1]};
   assign w_q_shift = {w_a_sum[0], r_q[32:1]};
   assign w_product = {w_a_sum[31:0], r_q[32:1]};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_m     <= '0;
         r_a     <= '0;
         r_q     <= '0;
         r_q1    <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_m     <= w_m_ext;
                  r_q     <= w_q_ext;
                  r_a     <= '0;
                  r_q1    <= 1'b0;
                  r_cnt   <= 6'd33;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_a   <= w_a_shift;
               r_q   <= w_q_shift;
               r_q1  <= r_q[0];
               r_cnt <= r_cnt - 6'd1;
               if (r_cnt == 6'd1) begin
                  r_hi    <= w_product[63:32];
                  r_lo    <= w_product[31:0];
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule
